// File: rtl/phase_unwrapper.sv
// rtl/phase_unwrapper.sv - removes +/-PI wraps from CORDIC phase and accumulates a wide continuous phase
// Two-stage pipeline: stage 1 forms the wrapped difference, stage 2 saturating-accumulates it.
module phase_unwrapper #(
    parameter int BIT_WIDTH_IN  = 27,
    parameter int BIT_WIDTH_OUT = 40,
    parameter int PI            = 26353586
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            clear_i,
    input  logic                            phi_valid_i,
    input  logic signed [BIT_WIDTH_IN-1:0]  phi_i,
    output logic signed [BIT_WIDTH_OUT-1:0] phi_unwrapped_o,
    output logic                            valid_o,
    output logic                            overflow_o
);

    localparam int WD = BIT_WIDTH_IN + 1;
    localparam logic signed [WD-1:0] PI_D     = WD'(PI);
    localparam logic signed [WD-1:0] TWO_PI_D = WD'(2 * PI);
    localparam logic signed [BIT_WIDTH_OUT-1:0] ACC_MAX = {1'b0, {(BIT_WIDTH_OUT-1){1'b1}}};
    localparam logic signed [BIT_WIDTH_OUT-1:0] ACC_MIN = {1'b1, {(BIT_WIDTH_OUT-1){1'b0}}};

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_first;

    logic signed [BIT_WIDTH_IN-1:0]  r_phi_prev;
    logic                            r_s1_valid;
    logic                            r_s1_first;
    logic signed [BIT_WIDTH_IN-1:0]  r_s1_phi;
    logic signed [WD-1:0]            r_s1_delta;
    logic signed [BIT_WIDTH_OUT-1:0] r_acc;
    logic                            r_valid;
    logic                            r_ovf;

    logic signed [WD-1:0]            w_raw;
    logic signed [WD-1:0]            w_delta;
    logic signed [BIT_WIDTH_OUT:0]   w_sum;
    logic signed [BIT_WIDTH_OUT-1:0] w_first_ext;

    // An accepted sample always leaves us tracking, even when it arrives with clear.
    always_comb begin
        w_state_nxt = r_state;
        w_first     = (r_state == WAIT_FIRST) || clear_i;
        if (phi_valid_i) begin
            w_state_nxt = TRACK;
        end else if (clear_i) begin
            w_state_nxt = WAIT_FIRST;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= WAIT_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_raw   = {phi_i[BIT_WIDTH_IN-1], phi_i} - {r_phi_prev[BIT_WIDTH_IN-1], r_phi_prev};
        w_delta = w_raw;
        if (w_raw > PI_D) begin
            w_delta = w_raw - TWO_PI_D;
        end else if (w_raw < -PI_D) begin
            w_delta = w_raw + TWO_PI_D;
        end
    end

    // One guard bit above the accumulator: disagreement with the MSB means we left the range.
    assign w_sum = {r_acc[BIT_WIDTH_OUT-1], r_acc}
                 + {{(BIT_WIDTH_OUT+1-WD){r_s1_delta[WD-1]}}, r_s1_delta};
    assign w_first_ext = {{(BIT_WIDTH_OUT-BIT_WIDTH_IN){r_s1_phi[BIT_WIDTH_IN-1]}}, r_s1_phi};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_phi_prev <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_phi   <= '0;
            r_s1_delta <= '0;
        end else begin
            r_s1_valid <= phi_valid_i;
            if (phi_valid_i) begin
                r_s1_first <= w_first;
                r_s1_phi   <= phi_i;
                r_s1_delta <= w_delta;
                r_phi_prev <= phi_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (clear_i) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_s1_valid) begin
                r_valid <= 1'b1;
                if (r_s1_first) begin
                    r_acc <= w_first_ext;
                end else if (w_sum[BIT_WIDTH_OUT] != w_sum[BIT_WIDTH_OUT-1]) begin
                    r_acc <= w_sum[BIT_WIDTH_OUT] ? ACC_MIN : ACC_MAX;
                    r_ovf <= 1'b1;
                end else begin
                    r_acc <= w_sum[BIT_WIDTH_OUT-1:0];
                end
            end
        end
    end

    assign phi_unwrapped_o = r_acc;
    assign valid_o         = r_valid;
    assign overflow_o      = r_ovf;

endmodule

// File: tb/tb_phase_unwrapper.sv
// tb/tb_phase_unwrapper.sv - directed vectors plus randomized model check for phase_unwrapper
module tb_phase_unwrapper;

    localparam longint PI_L  = 26353586;
    localparam longint TP_L  = 2 * PI_L;

    logic               clk;
    logic               reset_i;
    logic               clear_i;
    logic               phi_valid_i;
    logic signed [26:0] phi_i;
    logic signed [39:0] out_a;
    logic               valid_a;
    logic               ovf_a;
    logic signed [27:0] out_b;
    logic               valid_b;
    logic               ovf_b;

    int n_pass  = 0;
    int n_total = 0;

    phase_unwrapper #(.BIT_WIDTH_IN(27), .BIT_WIDTH_OUT(40), .PI(26353586)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .phi_valid_i(phi_valid_i),
        .phi_i(phi_i), .phi_unwrapped_o(out_a), .valid_o(valid_a), .overflow_o(ovf_a)
    );

    phase_unwrapper #(.BIT_WIDTH_IN(27), .BIT_WIDTH_OUT(28), .PI(26353586)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .phi_valid_i(phi_valid_i),
        .phi_i(phi_i), .phi_unwrapped_o(out_b), .valid_o(valid_b), .overflow_o(ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit     rst;
        bit     clr;
        bit     v;
        longint phi;
        bit     ev;
        longint eval;
        bit     eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit clr, input bit v, input longint phi,
                       input bit ev, input longint eval, input bit eovf);
        vec_t e;
        e.rst = rst; e.clr = clr; e.v = v; e.phi = phi;
        e.ev = ev; e.eval = eval; e.eovf = eovf;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input bit av, input longint aval, input bit aovf,
                       input bit ev, input longint eval, input bit eovf);
        n_total++;
        if (av === ev && aval == eval && aovf === eovf) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got valid=%0b val=%0d ovf=%0b, want valid=%0b val=%0d ovf=%0b",
                     name, av, aval, aovf, ev, eval, eovf);
        end
    endtask

    task automatic drive(input bit rst, input bit clr, input bit v, input longint phi);
        reset_i     = rst;
        clear_i     = clr;
        phi_valid_i = v;
        phi_i       = 27'(phi);
        @(posedge clk);
        #1;
    endtask

    function automatic longint wrap(input longint x);
        longint m;
        m = x % TP_L;
        if (m > PI_L) m -= TP_L;
        if (m < -PI_L) m += TP_L;
        return m;
    endfunction

    // Reference model: pending samples wait one cycle in a queue, then land in the accumulator.
    typedef struct {
        bit     first;
        longint phi;
        longint delta;
    } samp_t;

    samp_t  m_pend[2][$];
    bit     m_track[2];
    longint m_prev[2];
    longint m_acc[2];
    bit     m_ovf[2];
    bit     m_valid[2];
    int     m_w[2] = '{40, 28};

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k].delete();
            m_track[k] = 0; m_prev[k] = 0; m_acc[k] = 0; m_ovf[k] = 0; m_valid[k] = 0;
        end
    endfunction

    function automatic void model_step(input bit clr, input bit v, input longint phi);
        for (int k = 0; k < 2; k++) begin
            longint hi, lo, s, raw;
            samp_t  p;
            hi = (longint'(1) <<< (m_w[k] - 1)) - 1;
            lo = -(longint'(1) <<< (m_w[k] - 1));
            m_valid[k] = 0;
            if (clr) begin
                m_pend[k].delete();
                m_acc[k] = 0;
                m_ovf[k] = 0;
            end else if (m_pend[k].size() > 0) begin
                p = m_pend[k].pop_front();
                m_valid[k] = 1;
                if (p.first) begin
                    m_acc[k] = p.phi;
                end else begin
                    s = m_acc[k] + p.delta;
                    if (s > hi) begin m_acc[k] = hi; m_ovf[k] = 1; end
                    else if (s < lo) begin m_acc[k] = lo; m_ovf[k] = 1; end
                    else m_acc[k] = s;
                end
            end
            if (v) begin
                raw = phi - m_prev[k];
                if (raw > PI_L) raw -= TP_L;
                else if (raw < -PI_L) raw += TP_L;
                p.first = !m_track[k] || clr;
                p.phi   = phi;
                p.delta = raw;
                m_pend[k].push_back(p);
                m_prev[k]  = phi;
                m_track[k] = 1;
            end else if (clr) begin
                m_track[k] = 0;
            end
        end
    endfunction

    longint phis[10];
    longint exp_b[9];

    initial begin
        reset_i = 1'b1; clear_i = 1'b0; phi_valid_i = 1'b0; phi_i = '0;

        add(1,0,0,0,          0,0,0);
        add(0,0,1,1000,       0,0,0);
        add(0,0,0,0,          1,1000,0);
        add(0,0,0,0,          0,1000,0);
        add(1,0,0,0,          0,0,0);
        add(0,0,1,26000000,   0,0,0);
        add(0,0,1,-26000000,  1,26000000,0);
        add(0,0,0,0,          1,26707172,0);
        add(0,0,0,0,          0,26707172,0);
        add(1,0,0,0,          0,0,0);
        add(0,0,1,-26000000,  0,0,0);
        add(0,0,1,26000000,   1,-26000000,0);
        add(0,0,0,0,          1,-26707172,0);
        add(1,0,0,0,          0,0,0);
        add(0,0,1,0,          0,0,0);
        add(0,0,1,26353586,   1,0,0);
        add(0,0,0,0,          1,26353586,0);
        add(1,0,0,0,          0,0,0);
        add(0,0,1,0,          0,0,0);
        add(0,0,1,26353587,   1,0,0);
        add(0,0,0,0,          1,-26353585,0);
        add(1,0,0,0,          0,0,0);
        add(0,0,1,5000,       0,0,0);
        add(0,0,0,0,          1,5000,0);
        add(0,0,1,7000,       0,5000,0);
        add(0,1,1,-300,       0,0,0);
        add(0,0,0,0,          1,-300,0);
        add(0,0,0,0,          0,-300,0);
        add(1,0,0,0,          0,0,0);
        add(0,0,1,4000,       0,0,0);
        add(1,0,0,0,          0,0,0);
        add(0,0,0,0,          0,0,0);
        add(0,0,1,26353587,   0,0,0);
        add(0,0,0,0,          1,26353587,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].v, vecs[i].phi);
            chk($sformatf("vec%0d", i), valid_a, longint'(out_a), ovf_a,
                vecs[i].ev, vecs[i].eval, vecs[i].eovf);
        end

        // Saturation ramp on the narrow instance, wide instance tracks unclipped.
        for (int k = 0; k < 8; k++) phis[k] = wrap(longint'(k) * 20000000);
        phis[8] = wrap(120000000);
        phis[9] = 0;
        for (int k = 0; k < 7; k++) exp_b[k] = longint'(k) * 20000000;
        exp_b[7] = 134217727;
        exp_b[8] = 114217727;
        drive(1, 0, 0, 0);
        for (int j = 0; j < 10; j++) begin
            drive(0, 0, (j < 9), phis[j]);
            if (j >= 1) begin
                chk($sformatf("sat_b%0d", j - 1), valid_b, longint'(out_b), ovf_b,
                    1, exp_b[j-1], (j - 1 >= 7));
            end
        end
        chk("sat_a_unclipped", 1'b1, longint'(out_a), ovf_a, 1, 120000000, 0);
        drive(0, 1, 0, 0);
        chk("sat_b_clear", valid_b, longint'(out_b), ovf_b, 0, 0, 0);

        // Randomized run against the model on both widths.
        drive(1, 0, 0, 0);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit     v, clr;
            longint phi;
            int     r;
            v   = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 19) == 0) begin
                r   = int'($urandom) >>> 5;
                phi = longint'(r);
            end else begin
                phi = longint'($urandom_range(0, 52707172)) - PI_L;
            end
            drive(0, clr, v, phi);
            model_step(clr, v, phi);
            chk($sformatf("rand_a%0d", c), valid_a, longint'(out_a), ovf_a,
                m_valid[0], m_acc[0], m_ovf[0]);
            chk($sformatf("rand_b%0d", c), valid_b, longint'(out_b), ovf_b,
                m_valid[1], m_acc[1], m_ovf[1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
